// File: rtl/team_06_lcd_pkg.sv
// Shared definitions for the HD44780 line writer.
//   state_e    : top-level refresh FSM states
//   tx_phase_e : byte transmitter phases
//   CMD_*      : HD44780 command bytes used by init and line addressing
//   row_char() : pick character k (0 = leftmost) out of a 128-bit row
//   init_cmd() : k-th byte of the power-on init sequence
package team_06_lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP, INIT, IDLE, SNAP, ADDR1, ROW1, ADDR2, ROW2
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_SETUP, TX_EN, TX_WAIT
  } tx_phase_e;

  localparam logic [7:0] CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLR   = 8'h01;  // clear display (slow)
  localparam logic [7:0] CMD_L1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_L2    = 8'hC0;  // DDRAM address 0x40
  localparam logic [7:0] CHR_SPACE = 8'h20;

  // Character k sits in bits [127-8k -: 8].
  function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] k);
    logic [6:0] base;
    base = 7'd127 - {k, 3'b000};
    return row[base -: 8];
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] k);
    logic [7:0] c;
    unique case (k)
      2'd0:    c = CMD_FUNC;
      2'd1:    c = CMD_DISP;
      2'd2:    c = CMD_ENTRY;
      default: c = CMD_CLR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/team_06_lcd_byte_tx.sv
// One HD44780 byte write: 1 setup cycle (en=0), EN_CYC cycles en=1, then
// DELAY_CYC (or CLR_CYC when long_wait) cycles en=0. rs/data are registered
// at start and stay stable through the whole transfer.
// Ports:
//   clk, nrst        : clock, async active-low reset
//   start            : accept rs/byte_in/long_wait (only honoured when ready)
//   rs, byte_in      : register select and byte to write
//   long_wait        : use CLR_CYC instead of DELAY_CYC for the post-strobe wait
//   ready            : a new start may be issued this cycle
//   lcd_rs/en/data   : registered pins
module team_06_lcd_byte_tx
  import team_06_lcd_pkg::*;
#(
  parameter int unsigned EN_CYC    = 10,
  parameter int unsigned DELAY_CYC = 500,
  parameter int unsigned CLR_CYC   = 20000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] byte_in,
  input  logic       long_wait,
  output logic       ready,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int unsigned MAX_A   = (EN_CYC > DELAY_CYC) ? EN_CYC : DELAY_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > CLR_CYC) ? MAX_A : CLR_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);

  tx_phase_e        phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             long_q, long_d;
  logic [7:0]       data_q, data_d;
  logic             wait_last;

  assign wait_last = (phase_q == TX_WAIT) && (cnt_q == (long_q ? CLR_LAST : DLY_LAST));
  // Ready during the final wait cycle too, so the next byte's setup cycle
  // directly follows and a byte costs exactly 1+EN_CYC+wait cycles.
  assign ready = (phase_q == TX_IDLE) || wait_last;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    unique case (phase_q)
      TX_SETUP: begin
        phase_d = TX_EN;
        cnt_d   = '0;
      end
      TX_EN: begin
        if (cnt_q == EN_LAST) begin
          phase_d = TX_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_WAIT: begin
        if (wait_last) phase_d = TX_IDLE;
        else           cnt_d   = cnt_q + 1'b1;
      end
      default: ;
    endcase
    if (start && ready) begin
      phase_d = TX_SETUP;
      cnt_d   = '0;
      rs_d    = rs;
      data_d  = byte_in;
      long_d  = long_wait;
    end
    en_d = (phase_d == TX_EN);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase_q <= TX_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      long_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      long_q  <= long_d;
      data_q  <= data_d;
    end
  end

  assign lcd_rs   = rs_q;
  assign lcd_en   = en_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/team_06_lcd_writer.sv
// Two-line 16x2 HD44780 writer: power-up wait, init sequence, then on request
// snapshots row_1/row_2 and writes 0x80, 16 chars, 0xC0, 16 chars.
// Optional feature macro: LCD_AUTO_REFRESH_EN -- IDLE also starts a refresh
// whenever row_1/row_2 differ from the last snapshot.
// Ports:
//   clk, nrst      : clock, async active-low reset
//   row_1, row_2   : line text, char k in bits [127-8k -: 8]
//   update         : one-cycle refresh request (merged into a pending flag when busy)
//   busy           : FSM not in IDLE
//   done           : one-cycle pulse at end of a refresh
//   lcd_rs/rw/en/data : HD44780 bus (rw tied low)
module team_06_lcd_writer
  import team_06_lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC = 150000,
  parameter int unsigned EN_CYC      = 10,
  parameter int unsigned DELAY_CYC   = 500,
  parameter int unsigned CLR_CYC     = 20000
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [127:0] row_1,
  input  logic [127:0] row_2,
  input  logic         update,
  output logic         busy,
  output logic         done,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data
);

  localparam int unsigned PWR_W = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(POWERUP_CYC - 1);

  state_e           state_q, state_d;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [127:0]     snap1_q, snap1_d, snap2_q, snap2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tx_start, tx_rs, tx_long, tx_ready;
  logic [7:0]       tx_byte;
  logic             auto_go;

`ifdef LCD_AUTO_REFRESH_EN
  assign auto_go = (row_1 != snap1_q) || (row_2 != snap2_q);
`else
  assign auto_go = 1'b0;
`endif

  // Each state is entered in the same cycle its byte is handed to the
  // transmitter, so successive bytes run back to back.
  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    idx_d     = idx_q;
    snap1_d   = snap1_q;
    snap2_d   = snap2_q;
    done_d    = 1'b0;
    tx_start  = 1'b0;
    tx_rs     = 1'b0;
    tx_byte   = 8'h00;
    unique case (state_q)
      PWRUP: begin
        if (pwr_cnt_q == PWR_LAST) begin
          if (tx_ready) begin
            tx_start = 1'b1;
            tx_byte  = CMD_FUNC;
            idx_d    = '0;
            state_d  = INIT;
          end
        end else begin
          pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end
      INIT: begin
        if (tx_ready) begin
          if (idx_q == 4'd3) begin
            state_d = IDLE;
          end else begin
            tx_start = 1'b1;
            tx_byte  = init_cmd(idx_q[1:0] + 2'd1);
            idx_d    = idx_q + 4'd1;
          end
        end
      end
      IDLE: begin
        if (update || pend_q || auto_go) state_d = SNAP;
      end
      SNAP: begin
        if (tx_ready) begin
          snap1_d  = row_1;
          snap2_d  = row_2;
          tx_start = 1'b1;
          tx_byte  = CMD_L1;
          state_d  = ADDR1;
        end
      end
      ADDR1: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          tx_rs    = 1'b1;
          tx_byte  = row_char(snap1_q, 4'd0);
          idx_d    = '0;
          state_d  = ROW1;
        end
      end
      ROW1: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          if (idx_q == 4'd15) begin
            tx_byte = CMD_L2;
            state_d = ADDR2;
          end else begin
            tx_rs   = 1'b1;
            tx_byte = row_char(snap1_q, idx_q + 4'd1);
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      ADDR2: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          tx_rs    = 1'b1;
          tx_byte  = row_char(snap2_q, 4'd0);
          idx_d    = '0;
          state_d  = ROW2;
        end
      end
      ROW2: begin
        if (tx_ready) begin
          if (idx_q == 4'd15) begin
            // last char's wait ends this cycle
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tx_start = 1'b1;
            tx_rs    = 1'b1;
            tx_byte  = row_char(snap2_q, idx_q + 4'd1);
            idx_d    = idx_q + 4'd1;
          end
        end
      end
      default: state_d = PWRUP;
    endcase

    // Requests seen while busy collapse into one; cleared as SNAP is entered.
    if (state_q == IDLE && state_d == SNAP) pend_d = 1'b0;
    else if (update && state_q != IDLE)     pend_d = 1'b1;
    else                                    pend_d = pend_q;

    busy_d = (state_d != IDLE);
  end

  assign tx_long = !tx_rs && (tx_byte == CMD_CLR);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= PWRUP;
      pwr_cnt_q <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      snap1_q   <= {16{CHR_SPACE}};
      snap2_q   <= {16{CHR_SPACE}};
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwr_cnt_q <= pwr_cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      snap1_q   <= snap1_d;
      snap2_q   <= snap2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  team_06_lcd_byte_tx #(
    .EN_CYC   (EN_CYC),
    .DELAY_CYC(DELAY_CYC),
    .CLR_CYC  (CLR_CYC)
  ) u_tx (
    .clk      (clk),
    .nrst     (nrst),
    .start    (tx_start),
    .rs       (tx_rs),
    .byte_in  (tx_byte),
    .long_wait(tx_long),
    .ready    (tx_ready),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_team_06_lcd_writer.sv
// Bench for team_06_lcd_writer with short timing parameters. A bus monitor
// records every byte at its enable rising edge; a byte-sequence model built
// from the line-write rules gives the expected stream for each refresh.
module tb_team_06_lcd_writer;
  localparam int P_PWR = 20, P_EN = 2, P_DLY = 4, P_CLR = 8;
  localparam int LAT   = 1 + 34 * (1 + P_EN + P_DLY);

  logic         clk = 1'b0, nrst = 1'b0, update = 1'b0;
  logic [127:0] row_1 = {16{8'h20}}, row_2 = {16{8'h20}};
  logic         busy, done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]   lcd_data;

  int n_cmp = 0, n_err = 0, cyc = 0, last_fall = 0;
  logic [8:0] exp_q[$], got_q[$];

  team_06_lcd_writer #(.POWERUP_CYC(P_PWR), .EN_CYC(P_EN), .DELAY_CYC(P_DLY), .CLR_CYC(P_CLR)) dut (
    .clk(clk), .nrst(nrst), .row_1(row_1), .row_2(row_2), .update(update),
    .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // bus monitor
  logic       en_prev = 1'b0;
  logic [8:0] prev_bus = '0, cur_bus = '0;
  int         hi_cnt = 0;
  always @(negedge clk) begin
    if (!nrst) begin
      en_prev = 1'b0;
      hi_cnt  = 0;
    end else begin
      if (lcd_en && !en_prev) begin
        chk("setup", prev_bus, {lcd_rs, lcd_data});
        cur_bus = {lcd_rs, lcd_data};
        got_q.push_back(cur_bus);
        hi_cnt = 1;
      end else if (lcd_en) begin
        hi_cnt++;
        chk("hold", {lcd_rs, lcd_data}, cur_bus);
      end else if (en_prev) begin
        chk("en_width", hi_cnt, P_EN);
        last_fall = cyc;
      end
      en_prev = lcd_en;
    end
    prev_bus = {lcd_rs, lcd_data};
  end

  function automatic void push_refresh(input logic [127:0] a, input logic [127:0] b);
    exp_q.push_back(9'h080);
    for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, a[127-8*k -: 8]});
    exp_q.push_back(9'h0C0);
    for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, b[127-8*k -: 8]});
  endfunction

  function automatic logic [127:0] rnd_row();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'($urandom_range(32, 254));
    return r;
  endfunction

  task automatic check_bytes(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_en"}, lcd_en, 0);
    chk({tag, "_rs"}, lcd_rs, 0);
    chk({tag, "_rw"}, lcd_rw, 0);
    chk({tag, "_data"}, lcd_data, 8'h00);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4 * LAT) begin @(negedge clk); n++; end
    chk("idle_wait", busy, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 4 * LAT) begin @(negedge clk); lat++; end
  endtask

  // called at a negedge; SNAP follows the next posedge
  task automatic kick(input logic [127:0] a, input logic [127:0] b);
    row_1 = a; row_2 = b; update = 1'b1;
    @(negedge clk); update = 1'b0;
  endtask

  task automatic pulse();
    update = 1'b1; @(negedge clk); update = 1'b0;
  endtask

  task automatic do_init();
    int quiet = 0;
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006); exp_q.push_back(9'h001);
    @(negedge clk); nrst = 1'b1;
    repeat (P_PWR) begin @(negedge clk); if (lcd_en) quiet++; end
    chk("pwrup_quiet", quiet, 0);
    wait_idle();
    chk("clr_wait", cyc - last_fall, P_CLR);
    check_bytes("init");
  endtask

  task automatic run_refresh(input string tag, input logic [127:0] a, input logic [127:0] b);
    int lat;
    wait_idle();
    push_refresh(a, b);
    kick(a, b);
    wait_done(lat);
    chk({tag, "_lat"}, lat, LAT);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    check_bytes(tag);
  endtask

  initial begin
    logic [127:0] a, b, c, d;
    int lat, el, n;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    do_init();

    run_refresh("echo", {"ECHO", {12{8'h20}}}, {16{8'hFF}});
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      run_refresh("rand", rnd_row(), rnd_row());
    end

    // row change mid-refresh: output follows the snapshot
    a = rnd_row(); b = rnd_row(); c = rnd_row();
    wait_idle();
    push_refresh(a, b);
    kick(a, b);
    repeat (60) @(negedge clk);
    row_1 = c;
    wait_done(lat);
    chk("mid_lat", lat + 60, LAT);
`ifdef LCD_AUTO_REFRESH_EN
    push_refresh(c, b);
`endif
    repeat (LAT + 60) @(negedge clk);
    chk("mid_idle", busy, 0);
    check_bytes("midchg");

    // three requests during a refresh merge into one extra refresh
    a = rnd_row(); b = rnd_row(); c = rnd_row(); d = rnd_row();
    wait_idle();
    push_refresh(a, b);
    push_refresh(c, d);
    kick(a, b);
    el = 0;
    repeat (29) @(negedge clk); el += 29;
    pulse(); el += 1;
    repeat (40) @(negedge clk); el += 40;
    row_1 = c; row_2 = d;
    pulse(); el += 1;
    repeat (40) @(negedge clk); el += 40;
    pulse(); el += 1;
    wait_done(lat);
    chk("multi_lat", lat + el, LAT);
    @(negedge clk);
    wait_done(lat);
    chk("pend_lat", lat, LAT);
    repeat (LAT + 20) @(negedge clk);
    chk("multi_idle", busy, 0);
    check_bytes("multi");

    // update in the done cycle starts the next refresh right away
    a = rnd_row(); b = rnd_row(); c = rnd_row(); d = rnd_row();
    wait_idle();
    push_refresh(a, b);
    push_refresh(c, d);
    kick(a, b);
    wait_done(lat);
    chk("coin_lat1", lat, LAT);
    row_1 = c; row_2 = d;
    pulse();
    wait_done(lat);
    chk("coin_lat2", lat, LAT);
    @(negedge clk);
    check_bytes("coincide");

    // reset while enable is high
    wait_idle();
    kick(rnd_row(), rnd_row());
    n = 0;
    while (!lcd_en && n < 100) begin @(negedge clk); n++; end
    chk("en_seen", lcd_en, 1);
    #2 nrst = 1'b0;
    row_1 = {16{8'h20}}; row_2 = {16{8'h20}};
    #1 chk("en_async", lcd_en, 0);
    @(negedge clk);
    check_reset_vals("rst2");
    got_q.delete(); exp_q.delete();
    do_init();
    run_refresh("post_rst", rnd_row(), rnd_row());

`ifdef LCD_AUTO_REFRESH_EN
    // IDLE picks up a row change with no request
    wait_idle();
    b = rnd_row();
    push_refresh(row_1, b);
    row_2 = b;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    chk("auto_start", busy, 1);
    wait_done(lat);
    chk("auto_done", done, 1);
    @(negedge clk);
    check_bytes("auto");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
